// File: rtl/descrambler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : descrambler_ctrl
//  Description : Frame sequencer for the 802.11a serial descrambler. Sizes the
//                padded DATA field by repeated addition of N_DBPS, recovers the
//                7-bit scrambler seed from the first SERVICE bits, then streams
//                the remaining bits to the descrambler with a field tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module descrambler_ctrl #(
   parameter int LEN_W = 12,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] psdu_len,
   input  logic [8:0]       ndbps,
   input  logic             abort,
   input  logic             rx_valid,
   input  logic             rx_bit,
   output logic             rx_ready,
   output logic             ds_load,
   output logic [6:0]       ds_seed,
   output logic             ds_en,
   output logic             ds_rx,
   output logic [1:0]       field,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_CALC   = 2'd1;
   localparam logic [1:0] c_SEED   = 2'd2;
   localparam logic [1:0] c_STREAM = 2'd3;

   localparam logic [8:0] c_NDBPS_MAX = 9'd216;

   localparam logic [1:0] c_FLD_SERVICE = 2'd0;
   localparam logic [1:0] c_FLD_PSDU    = 2'd1;
   localparam logic [1:0] c_FLD_TAIL    = 2'd2;
   localparam logic [1:0] c_FLD_PAD     = 2'd3;

   logic [1:0]       r_state;
   logic [LEN_W-1:0] r_len;
   logic [8:0]       r_ndbps;
   logic [CNT_W-1:0] r_need;
   logic [CNT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_total;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [6:0]       r_seed;
   logic             r_ds_load;
   logic [6:0]       r_ds_seed;
   logic             r_ds_en;
   logic             r_ds_rx;
   logic [1:0]       r_field;
   logic             r_done;
   logic             r_err;

   logic             w_rx_ready;
   logic             w_accept;
   logic [CNT_W-1:0] w_acc_next;
   logic [CNT_W-1:0] w_psdu_end;
   logic [1:0]       w_field;
   logic             w_last;
   logic             w_bad_ndbps;

   // Bits are not taken while the seed-load pulse is out, nor when abort wins.
   assign w_rx_ready = ~abort & ((r_state == c_SEED) |
                                 ((r_state == c_STREAM) & ~r_ds_load));
   assign w_accept    = rx_valid & w_rx_ready;
   assign w_acc_next  = r_acc + CNT_W'(r_ndbps);
   assign w_psdu_end  = CNT_W'(16) + (CNT_W'(r_len) << 3);
   assign w_last      = (r_bit_cnt == r_total - CNT_W'(1));
   assign w_bad_ndbps = (ndbps == 9'd0) | (ndbps > c_NDBPS_MAX);

   // Field tag of the bit currently being accepted, from its frame index.
   always_comb begin
      w_field = c_FLD_PAD;
      if (r_bit_cnt < CNT_W'(16))
         w_field = c_FLD_SERVICE;
      else if (r_bit_cnt < w_psdu_end)
         w_field = c_FLD_PSDU;
      else if (r_bit_cnt < r_need)
         w_field = c_FLD_TAIL;
   end

   // Frame sequencer: length calculation, seed capture and bit streaming.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= c_IDLE;
         r_len     <= '0;
         r_ndbps   <= '0;
         r_need    <= '0;
         r_acc     <= '0;
         r_total   <= '0;
         r_bit_cnt <= '0;
         r_seed    <= '0;
         r_ds_load <= 1'b0;
         r_ds_seed <= '0;
         r_ds_en   <= 1'b0;
         r_ds_rx   <= 1'b0;
         r_field   <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ds_load <= 1'b0;
         r_ds_en   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         if (r_state == c_IDLE) begin
            if (start) begin
               if (w_bad_ndbps) begin
                  r_err <= 1'b1;
               end else begin
                  r_len     <= psdu_len;
                  r_ndbps   <= ndbps;
                  r_need    <= CNT_W'(22) + (CNT_W'(psdu_len) << 3);
                  r_acc     <= '0;
                  r_bit_cnt <= '0;
                  r_seed    <= '0;
                  r_state   <= c_CALC;
               end
            end
         end else begin
            // A new start cannot preempt a running frame; flag it and carry on.
            if (start)
               r_err <= 1'b1;
            if (abort) begin
               r_state <= c_IDLE;
            end else begin
               case (r_state)
                  c_CALC: begin
                     r_acc <= w_acc_next;
                     if (w_acc_next >= r_need) begin
                        r_total <= w_acc_next;
                        r_state <= c_SEED;
                     end
                  end
                  c_SEED: begin
                     if (w_accept) begin
                        r_seed    <= {r_seed[5:0], rx_bit};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(6)) begin
                           r_ds_load <= 1'b1;
                           r_ds_seed <= {r_seed[5:0], rx_bit};
                           r_state   <= c_STREAM;
                        end
                     end
                  end
                  c_STREAM: begin
                     if (w_accept) begin
                        r_ds_en   <= 1'b1;
                        r_ds_rx   <= rx_bit;
                        r_field   <= w_field;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_last) begin
                           r_done  <= 1'b1;
                           r_state <= c_IDLE;
                        end
                     end
                  end
                  default: r_state <= c_IDLE;
               endcase
            end
         end
      end
   end

   assign rx_ready = w_rx_ready;
   assign ds_load  = r_ds_load;
   assign ds_seed  = r_ds_seed;
   assign ds_en    = r_ds_en;
   assign ds_rx    = r_ds_rx;
   assign field    = r_field;
   assign busy     = (r_state != c_IDLE);
   assign done     = r_done;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_descrambler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_descrambler_ctrl
//  Description : Randomized scoreboard bench for descrambler_ctrl. A frame-level
//                model predicts seed load and tagged bit events; a monitor pops
//                and compares them as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_descrambler_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] psdu_len = '0;
   logic [8:0]  ndbps = '0;
   logic        abort = 1'b0;
   logic        rx_valid = 1'b0;
   logic        rx_bit = 1'b0;
   logic        rx_ready, ds_load, ds_en, ds_rx, busy, done, err;
   logic [6:0]  ds_seed;
   logic [1:0]  field;

   typedef struct {
      bit         is_load;
      logic [6:0] seed;
      logic       rxb;
      logic [1:0] fld;
      logic       dn;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_mis = 0;
   int   exp_err = 0, err_seen = 0;
   int   exp_done = 0, done_seen = 0;
   logic fbits [0:4095];

   descrambler_ctrl #(.LEN_W(12), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .psdu_len(psdu_len), .ndbps(ndbps),
      .abort(abort), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(rx_ready),
      .ds_load(ds_load), .ds_seed(ds_seed), .ds_en(ds_en), .ds_rx(ds_rx),
      .field(field), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Field tag straight from the frame layout: 16 SERVICE, 8*len PSDU, 6 TAIL, rest PAD.
   function automatic logic [1:0] field_of(input int i, input int len);
      if (i < 16)                 return 2'd0;
      else if (i < 16 + 8 * len)  return 2'd1;
      else if (i < 22 + 8 * len)  return 2'd2;
      else                        return 2'd3;
   endfunction

   // Monitor: every load/enable event must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset) begin
         if (err)  err_seen++;
         if (done) done_seen++;
         if (ds_load || ds_en) begin
            if (q.size() == 0) begin
               chk("unexpected_event", {ds_load, ds_en}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.is_load)
                  chk("seed_load", {ds_load, ds_en, ds_seed}, {1'b1, 1'b0, e.seed});
               else
                  chk("stream_bit", {ds_load, ds_en, ds_rx, field, done},
                      {1'b0, 1'b1, e.rxb, e.fld, e.dn});
            end
         end else if (done) begin
            chk("done_without_en", 32'd1, 32'd0);
         end
      end
   end

   task automatic run_frame(input int len, input int nd, input int gap_pct, input int seed_fix,
                            input int abort_at, input int midstart_at, input int reset_at);
      int need, nsym, total, k, cyc, cnt;
      bit stopped, ms_done;
      logic [6:0] sd;
      exp_t e;
      need  = 22 + 8 * len;
      nsym  = (need + nd - 1) / nd;
      total = nsym * nd;
      for (int i = 0; i < total; i++) fbits[i] = 1'($urandom_range(0, 1));
      if (seed_fix >= 0)
         for (int i = 0; i < 7; i++) fbits[i] = 1'((seed_fix >> (6 - i)) & 1);
      psdu_len = 12'(len);
      ndbps    = 9'(nd);
      start    = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (rx_ready || cnt > 300) break;
         cnt++;
      end
      chk("calc_latency", cnt, nsym);
      @(posedge clk); #1;
      sd = '0; k = 0; cyc = 0; stopped = 0; ms_done = 0;
      while (k < total && !stopped && cyc < total * 5 + 200) begin
         rx_bit = fbits[k];
         if (abort_at == k) begin
            abort    = 1'b1;
            rx_valid = 1'b1;
         end else begin
            rx_valid = ($urandom_range(0, 99) >= gap_pct);
         end
         if (midstart_at == k && !ms_done) begin
            start = 1'b1; psdu_len = 12'd5; ndbps = 9'd24; ms_done = 1; exp_err++;
         end
         if (reset_at == k) begin
            rx_valid = 1'b0;
            #2 reset = 1'b0;
            #1 chk("async_reset_outputs",
                   {rx_ready, ds_load, ds_seed, ds_en, ds_rx, field, busy, done, err}, 32'd0);
            q.delete();
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            stopped = 1;
         end else begin
            @(negedge clk);
            if (abort) begin
               stopped = 1;
            end else if (rx_valid && rx_ready) begin
               if (k < 7) begin
                  sd[6 - k] = fbits[k];
                  if (k == 6) begin
                     e.is_load = 1; e.seed = sd; e.rxb = 0; e.fld = 0; e.dn = 0;
                     q.push_back(e);
                  end
               end else begin
                  e.is_load = 0; e.seed = '0; e.rxb = fbits[k];
                  e.fld = field_of(k, len); e.dn = (k == total - 1);
                  q.push_back(e);
               end
               k++;
            end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; rx_valid = 1'b0;
         end
         cyc++;
      end
      if (abort_at >= 0 && stopped) begin
         @(negedge clk);
         chk("abort_busy_low", busy, 0);
         @(posedge clk); #1;
      end
      if (!stopped && k < total) chk("frame_timeout", k, total);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      if (!stopped) exp_done++;
      chk("idle_after_frame", busy, 0);
      chk("done_count", done_seen, exp_done);
   endtask

   task automatic bad_start(input int nd);
      ndbps    = 9'(nd);
      psdu_len = 12'd10;
      start    = 1'b1;
      exp_err++;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("bad_ndbps_err", {err, busy}, 2'b10);
      @(posedge clk); #1;
      chk("bad_ndbps_idle", busy, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state",
          {rx_ready, ds_load, ds_seed, ds_en, ds_rx, field, busy, done, err}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      run_frame(0, 24, 0, -1, -1, -1, -1);              // T1
      run_frame(100, 216, 0, 7'b1011101, -1, -1, -1);    // T2
      run_frame(100, 216, 30, 7'b1011101, -1, -1, -1);   // T3
      run_frame(100, 216, 20, -1, 300, -1, -1);          // T4 abort
      run_frame(20, 48, 10, -1, -1, -1, -1);
      bad_start(0);                                      // T5
      bad_start(217);
      run_frame(100, 216, 0, 7'b1011101, -1, 400, -1);   // start mid-frame
      run_frame(100, 216, 0, -1, -1, -1, 200);           // T6 reset mid-stream
      run_frame(10, 96, 0, -1, -1, -1, -1);
      for (int f = 0; f < 4; f++)
         run_frame($urandom_range(0, 60), $urandom_range(24, 216), 30, -1, -1, -1, -1);
      run_frame(3, 216, 0, -1, 4, -1, -1);               // abort during seed capture
      run_frame(0, 216, 0, -1, -1, -1, -1);
      chk("err_count", err_seen, exp_err);
      chk("final_done_count", done_seen, exp_done);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
